hist_readout_collector: RTL and testbench
=========================================

HIST_READOUT_COLLECTOR -- requirements
Module: hist_readout_collector

Interface
REQ-001 Parameter: DATA_W, 8, width of one bin count beat.
REQ-002 Parameter: NUM_BINS, 16, bins per frame; power of two, 2..256; AW = clog2(NUM_BINS).
REQ-003 Port: clk  in  1  single clock; all state rising-edge.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: arm  in  1  request capture of next frame.
REQ-006 Port: bin_data  in  DATA_W  bin count beat from histogram readout.
REQ-007 Port: bin_valid  in  1  bin_data valid this cycle; no backpressure exists.
REQ-008 Port: bin_last  in  1  qualifies final beat of a frame; meaningful only with bin_valid.
REQ-009 Port: rd_addr  in  AW  bin readback address.
REQ-010 Port: rd_data  out  DATA_W  stored count at rd_addr, registered.
REQ-011 Port: busy  out  1  high in ARMED or CAPTURE.
REQ-012 Port: done  out  1  high in DONE.
REQ-013 Port: frame_done  out  1  one-cycle pulse on entry to DONE.
REQ-014 Port: frame_err  out  2  bit1 overflow, bit0 short frame.
REQ-015 Port: bins_rcvd  out  AW+1  beats stored in current/last frame.
REQ-016 Port: total_count  out  DATA_W+AW  sum of stored beats.
REQ-017 Port: peak_bin  out  AW  index of largest count.
REQ-018 Port: peak_count  out  DATA_W  largest count.

Function
REQ-019 FSM states IDLE, ARMED, CAPTURE, DONE SHALL be implemented; IDLE and DONE ignore bin_valid.
REQ-020 IDLE/DONE + arm -> ARMED next cycle; bins_rcvd, total_count, peak_bin, peak_count, frame_err cleared on that edge; bin storage not cleared.
REQ-021 ARMED + bin_valid SHALL store beat at index 0 and go CAPTURE (or DONE if bin_last); arm in same cycle has no further effect.
REQ-022 In CAPTURE each bin_valid beat SHALL be written to storage[bins_rcvd] and bins_rcvd incremented; arm ignored in ARMED and CAPTURE.
REQ-023 Beat with bin_last at index NUM_BINS-1 SHALL end the frame cleanly, frame_err = 0.
REQ-024 Beat with bin_last at index < NUM_BINS-1 SHALL end the frame with frame_err[0] = 1.
REQ-025 Beat at index NUM_BINS-1 without bin_last SHALL be stored, set frame_err[1] = 1 and end the frame; later beats ignored until re-armed.
REQ-026 Frame end SHALL enter DONE on the edge accepting the final beat; frame_done high for exactly that following cycle; all results stable there and held until next arm.
REQ-027 total_count SHALL be exact (no saturation possible at declared width), updated with each stored beat.
REQ-028 peak updates only on strictly greater count, so ties keep lowest index; first beat always loads peak.
REQ-029 rd_data SHALL equal storage[rd_addr] one cycle after rd_addr is sampled, in every state; same-cycle write/read returns old data.

Reset
REQ-030 Reset SHALL force IDLE and zero every output, counter and flag asynchronously; release synchronous to clk.
REQ-031 Reset mid-frame SHALL abandon the frame; storage contents undefined after reset.

Configuration
REQ-032 Macro HIST_COLLECT_STATS_EN defined: total_count, peak_bin, peak_count per REQ-027/028.
REQ-033 Macro undefined: statistic logic absent, those three outputs tied 0; capture, errors, readback unchanged.

Verification
REQ-034 Arm, 16 beats 1..16, last on 16th -> frame_done 1 cycle, frame_err=0, bins_rcvd=16, total_count=136, peak_bin=15, peak_count=16.
REQ-035 Arm, 5 beats 9,3,9,2,1, last on 5th -> frame_err=2'b01, bins_rcvd=5, total=24, peak_bin=0, peak_count=9.
REQ-036 Arm, 18 beats of 8'hFF, no last -> frame_err=2'b10 after 16th, bins_rcvd=16, total=4080, beats 17-18 ignored.
REQ-037 Beats with no arm, then in DONE -> no state change; rd_addr=3 after REQ-034 frame -> rd_data=4 next cycle.
REQ-038 Reset asserted after 7 beats -> outputs 0 immediately, IDLE; re-arm plus full frame captures correctly.
REQ-039 Build without HIST_COLLECT_STATS_EN, rerun REQ-034 -> stats outputs 0, all other results identical.

Source files
------------

// File: rtl/hist_readout_collector.sv
// Captures one histogram readout frame into bin storage, flags short/overflow frames and
// tracks running statistics when HIST_COLLECT_STATS_EN is defined (otherwise stats tie to 0).
module hist_readout_collector #(
    parameter int DATA_W   = 8,
    parameter int NUM_BINS = 16,
    localparam int AW      = $clog2(NUM_BINS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 arm,
    input  logic [DATA_W-1:0]    bin_data,
    input  logic                 bin_valid,
    input  logic                 bin_last,
    input  logic [AW-1:0]        rd_addr,
    output logic [DATA_W-1:0]    rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 frame_done,
    output logic [1:0]           frame_err,
    output logic [AW:0]          bins_rcvd,
    output logic [DATA_W+AW-1:0] total_count,
    output logic [AW-1:0]        peak_bin,
    output logic [DATA_W-1:0]    peak_count
);
    // state   | meaning
    // IDLE    | waiting for arm after reset
    // ARMED   | waiting for first beat of a frame
    // CAPTURE | storing beats until last beat or storage full
    // DONE    | frame complete, results held until next arm
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [AW:0]   ONE      = (AW+1)'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BINS - 1);

    state_t            state;
    logic [DATA_W-1:0] mem [NUM_BINS];
    logic [AW-1:0]     widx;
    logic              start;
    logic              accept;

    assign widx   = bins_rcvd[AW-1:0];
    assign start  = ((state == IDLE) || (state == DONE)) && arm;
    assign accept = ((state == ARMED) || (state == CAPTURE)) && bin_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 2'b00;
            bins_rcvd  <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= ARMED;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        frame_err <= 2'b00;
                        bins_rcvd <= '0;
                    end
                end
                ARMED, CAPTURE: begin
                    if (bin_valid) begin
                        bins_rcvd <= bins_rcvd + ONE;
                        // A beat landing in the last slot ends the frame whether or not it is flagged last.
                        if (bin_last || (widx == LAST_IDX)) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            frame_done <= 1'b1;
                            frame_err  <= {~bin_last, bin_last && (widx != LAST_IDX)};
                        end else begin
                            state <= CAPTURE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; contents are only meaningful for the bins of the last frame.
    always_ff @(posedge clk) begin
        if (accept) mem[widx] <= bin_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_addr];
    end

`ifdef HIST_COLLECT_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total_count <= '0;
            peak_bin    <= '0;
            peak_count  <= '0;
        end else if (start) begin
            total_count <= '0;
            peak_bin    <= '0;
            peak_count  <= '0;
        end else if (accept) begin
            total_count <= total_count + (DATA_W+AW)'(bin_data);
            // Strictly greater keeps the lowest index on ties; bin 0 always seeds the peak.
            if ((widx == '0) || (bin_data > peak_count)) begin
                peak_bin   <= widx;
                peak_count <= bin_data;
            end
        end
    end
`else
    assign total_count = '0;
    assign peak_bin    = '0;
    assign peak_count  = '0;
`endif

endmodule

// File: tb/tb_hist_readout_collector.sv
// Directed bench for hist_readout_collector: a beat model feeds a scoreboard queue that is
// drained through the readback port; frame results are compared against the model.
module tb_hist_readout_collector;
    localparam int DATA_W   = 8;
    localparam int NUM_BINS = 16;
    localparam int AW       = 4;
`ifdef HIST_COLLECT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                 clk;
    logic                 reset;
    logic                 arm;
    logic [DATA_W-1:0]    bin_data;
    logic                 bin_valid;
    logic                 bin_last;
    logic [AW-1:0]        rd_addr;
    logic [DATA_W-1:0]    rd_data;
    logic                 busy;
    logic                 done;
    logic                 frame_done;
    logic [1:0]           frame_err;
    logic [AW:0]          bins_rcvd;
    logic [DATA_W+AW-1:0] total_count;
    logic [AW-1:0]        peak_bin;
    logic [DATA_W-1:0]    peak_count;

    hist_readout_collector #(.DATA_W(DATA_W), .NUM_BINS(NUM_BINS)) dut (
        .clk(clk), .reset(reset), .arm(arm), .bin_data(bin_data), .bin_valid(bin_valid),
        .bin_last(bin_last), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
        .frame_done(frame_done), .frame_err(frame_err), .bins_rcvd(bins_rcvd),
        .total_count(total_count), .peak_bin(peak_bin), .peak_count(peak_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [DATA_W-1:0] sb [$];

    bit   m_armed;
    bit   m_done;
    int   m_cnt;
    int   m_total;
    int   m_pb;
    int   m_pc;
    logic [1:0] m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_done  = 1'b0;
        m_cnt   = 0;
        m_total = 0;
        m_pb    = 0;
        m_pc    = 0;
        m_err   = 2'b00;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
        model_clear();
        m_armed = 1'b1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        bin_valid = 1'b1;
        bin_data  = d;
        bin_last  = l;
        if (m_armed && !m_done) begin
            sb.push_back(d);
            m_total += int'(d);
            if (m_cnt == 0 || int'(d) > m_pc) begin
                m_pb = m_cnt;
                m_pc = int'(d);
            end
            if (l) begin
                m_done = 1'b1;
                m_err  = (m_cnt == NUM_BINS-1) ? 2'b00 : 2'b01;
            end else if (m_cnt == NUM_BINS-1) begin
                m_done = 1'b1;
                m_err  = 2'b10;
            end
            m_cnt++;
        end
        tick();
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic check_results(input string tag);
        check({tag, ".done"}, 32'(done), 32'(m_done));
        check({tag, ".busy"}, 32'(busy), 32'(m_armed && !m_done));
        check({tag, ".frame_err"}, 32'(frame_err), 32'(m_err));
        check({tag, ".bins_rcvd"}, 32'(bins_rcvd), 32'(m_cnt));
        check({tag, ".total_count"}, 32'(total_count), STATS ? 32'(m_total) : 32'd0);
        check({tag, ".peak_bin"}, 32'(peak_bin), STATS ? 32'(m_pb) : 32'd0);
        check({tag, ".peak_count"}, 32'(peak_count), STATS ? 32'(m_pc) : 32'd0);
    endtask

    task automatic readback(input string tag, input int n);
        logic [DATA_W-1:0] exp;
        for (int i = 0; i < n; i++) begin
            rd_addr = AW'(i);
            tick();
            if (sb.size() == 0) begin
                check({tag, ".sb_empty"}, 32'(sb.size()), 32'd1);
            end else begin
                exp = sb.pop_front();
                check({tag, ".rd_data"}, 32'(rd_data), 32'(exp));
            end
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, 32'(busy), 32'd0);
        check({tag, ".done"}, 32'(done), 32'd0);
        check({tag, ".frame_done"}, 32'(frame_done), 32'd0);
        check({tag, ".frame_err"}, 32'(frame_err), 32'd0);
        check({tag, ".bins_rcvd"}, 32'(bins_rcvd), 32'd0);
        check({tag, ".total_count"}, 32'(total_count), 32'd0);
        check({tag, ".peak_bin"}, 32'(peak_bin), 32'd0);
        check({tag, ".peak_count"}, 32'(peak_count), 32'd0);
        check({tag, ".rd_data"}, 32'(rd_data), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        arm       = 1'b0;
        bin_data  = '0;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
        rd_addr   = '0;
        m_armed   = 1'b0;
        model_clear();
        tick();
        tick();
        check_zero("reset");
        reset = 1'b0;
        tick();

        // Beats without arm are ignored in IDLE
        send(8'h33, 1'b0);
        send(8'h44, 1'b1);
        check_results("idle_beats");

        // Clean 16-beat frame, values 1..16
        do_arm();
        check("armed.busy", 32'(busy), 32'd1);
        check("armed.bins_rcvd", 32'(bins_rcvd), 32'd0);
        for (int i = 0; i < NUM_BINS; i++) begin
            send(8'(i + 1), i == NUM_BINS-1);
            if (i == 7) check("full.mid_bins", 32'(bins_rcvd), 32'd8);
        end
        check_results("full");
        check("full.frame_done", 32'(frame_done), 32'd1);
        check("full.total_const", 32'(total_count), STATS ? 32'd136 : 32'd0);
        tick();
        check("full.frame_done_drop", 32'(frame_done), 32'd0);
        check_results("full_hold");
        readback("full_rb", NUM_BINS);
        rd_addr = 4'd3;
        tick();
        check("full.rd3", 32'(rd_data), 32'd4);

        // Beats while in DONE change nothing, storage included
        send(8'hAA, 1'b1);
        send(8'hBB, 1'b0);
        check_results("done_beats");
        check("done_beats.frame_done", 32'(frame_done), 32'd0);
        rd_addr = 4'd0;
        tick();
        check("done_beats.rd0", 32'(rd_data), 32'd1);

        // Short frame; arm during capture is ignored
        do_arm();
        send(8'd9, 1'b0);
        arm = 1'b1;
        send(8'd3, 1'b0);
        arm = 1'b0;
        send(8'd9, 1'b0);
        send(8'd2, 1'b0);
        send(8'd1, 1'b1);
        check_results("short");
        check("short.frame_done", 32'(frame_done), 32'd1);
        check("short.err_const", 32'(frame_err), 32'd1);
        tick();
        readback("short_rb", 5);

        // Overflow: 18 beats of 0xFF with no last
        do_arm();
        for (int i = 0; i < NUM_BINS; i++) send(8'hFF, 1'b0);
        check_results("ovf");
        check("ovf.frame_done", 32'(frame_done), 32'd1);
        check("ovf.total_const", 32'(total_count), STATS ? 32'd4080 : 32'd0);
        send(8'hFF, 1'b0);
        send(8'hFF, 1'b0);
        check_results("ovf_extra");
        readback("ovf_rb", NUM_BINS);

        // Reset in the middle of a frame, then a fresh frame
        do_arm();
        for (int i = 0; i < 7; i++) send(8'($urandom_range(0, 255)), 1'b0);
        check("pre_rst.bins", 32'(bins_rcvd), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        check_zero("mid_reset");
        m_armed = 1'b0;
        model_clear();
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        check_results("post_reset");
        do_arm();
        for (int i = 0; i < NUM_BINS; i++) send(8'($urandom_range(0, 255)), i == NUM_BINS-1);
        check_results("rearm");
        check("rearm.frame_done", 32'(frame_done), 32'd1);
        readback("rearm_rb", NUM_BINS);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
